alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 53 +++++
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared defaults and FSM state encoding for the ALU arbiter slice.
//   ALU_DATA_W : default operand/result width
//   ALU_SEL_W  : default ALU operation-select width
//   state_e    : arbiter FSM states
package alu_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_SEL_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin selector over N_REQ request lines. The requester after the
// last accepted one has highest priority; after reset requester 0 does.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   req        : request vector
//   accept     : the current grant is taken this cycle (advances pointer)
//   grant      : one-hot grant (all zero when no request)
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             accept,
  output logic [N_REQ-1:0] grant
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] mask_hi;
  logic [N_REQ-1:0] req_hi;
  logic [N_REQ-1:0] pick;
  logic [IDX_W-1:0] idx_or [N_REQ+1];
  logic [IDX_W-1:0] grant_idx;

  // Requests at or above the pointer win first; otherwise wrap to the
  // full vector. The lowest set bit of the chosen vector is the grant.
  for (genvar g = 0; g < N_REQ; g++) begin : g_mask
    assign mask_hi[g] = (IDX_W'(g) >= ptr_q);
    assign idx_or[g+1] = idx_or[g] | (grant[g] ? IDX_W'(g) : '0);
  end
  assign idx_or[0]  = '0;
  assign grant_idx  = idx_or[N_REQ];

  assign req_hi = req & mask_hi;
  assign pick   = (|req_hi) ? req_hi : req;
  assign grant  = pick & (~pick + N_REQ'(1));

  always_comb begin
    ptr_d = ptr_q;
    if (accept && (|grant)) begin
      ptr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external combinational ALU between N_REQ requesters. A winner
// is picked round-robin in IDLE, its operands are registered to the ALU,
// the result is captured one cycle later and held until the winner takes it.
// Ports:
//   req_valid/req_ready        : per-requester request / accept strobe
//   req_a/req_b/req_sel        : packed per-requester operands, slice i = req i
//   rsp_valid/rsp_ready        : per-requester response handshake
//   rsp_data/rsp_carry         : registered ALU result
//   alu_a/alu_b/alu_sel        : registered operands to the shared ALU
//   alu_out/alu_carry          : shared ALU result
//   busy                       : FSM not in IDLE
//
// state   | meaning
// IDLE    | waiting for any request; grants winner and loads ALU operands
// EXEC    | ALU evaluating; result captured at end of cycle
// RESP    | result presented to winner until its rsp_ready
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int SEL_W  = ALU_SEL_W,
  parameter int N_REQ  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ*SEL_W-1:0]  req_sel,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_carry,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic [SEL_W-1:0]        alu_sel,
  input  logic [DATA_W-1:0]       alu_out,
  input  logic                    alu_carry,
  output logic                    busy
);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   winner_q, winner_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_carry_q, rsp_carry_d;

  logic [N_REQ-1:0]   grant;
  logic               accept;

  // One-hot grant turns the operand mux into an AND-OR chain.
  logic [DATA_W-1:0]  a_or   [N_REQ+1];
  logic [DATA_W-1:0]  b_or   [N_REQ+1];
  logic [SEL_W-1:0]   sel_or [N_REQ+1];

  assign a_or[0]   = '0;
  assign b_or[0]   = '0;
  assign sel_or[0] = '0;
  for (genvar g = 0; g < N_REQ; g++) begin : g_mux
    assign a_or[g+1]   = a_or[g]   | (req_a[g*DATA_W +: DATA_W] & {DATA_W{grant[g]}});
    assign b_or[g+1]   = b_or[g]   | (req_b[g*DATA_W +: DATA_W] & {DATA_W{grant[g]}});
    assign sel_or[g+1] = sel_or[g] | (req_sel[g*SEL_W +: SEL_W] & {SEL_W{grant[g]}});
  end

  assign accept = (state_q == ST_IDLE) && (|req_valid);

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    req_ready   = '0;
    rsp_valid   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_ready = grant;
          winner_d  = grant;
          alu_a_d   = a_or[N_REQ];
          alu_b_d   = b_or[N_REQ];
          alu_sel_d = sel_or[N_REQ];
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = alu_out;
        rsp_carry_d = alu_carry;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = winner_q;
        // Only the winner's rsp_ready can release the response.
        if (|(rsp_ready & winner_q)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      winner_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Self-checking bench for alu_arbiter with two requesters. The shared ALU
// is modelled here (sel 0 add with carry, sel 1 subtract with borrow,
// other selects XOR). Expected grants come from a round-robin model that
// tracks only the last granted requester.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [15:0] req_a, req_b;
  logic [7:0]  req_sel;
  logic [7:0]  rsp_data, alu_a, alu_b, alu_out;
  logic        rsp_carry, alu_carry, busy;
  logic [3:0]  alu_sel;

  int errors = 0;
  int checks = 0;
  int last_grant = 1;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(8), .SEL_W(4), .N_REQ(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .busy(busy)
  );

  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] sel);
    logic [8:0] r;
    case (sel)
      4'd0:    r = {1'b0, a} + {1'b0, b};
      4'd1:    r = {1'b0, a} - {1'b0, b};
      default: r = {1'b0, a ^ b};
    endcase
    return r;
  endfunction

  assign {alu_carry, alu_out} = alu_ref(alu_a, alu_b, alu_sel);

  function automatic logic [1:0] oh(input int i);
    return 2'(2'b01 << i);
  endfunction

  // Next requester after 'last' that is asking; -1 when nobody asks.
  function automatic int rr_pick(input logic [1:0] v, input int last);
    for (int k = 1; k <= 2; k++) begin
      int c;
      c = (last + k) % 2;
      if ((v & oh(c)) != 2'b00) return c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] slice8(input logic [15:0] v, input int i);
    return 8'(v >> (8 * i));
  endfunction

  task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel);
    req_a   = (req_a & ~(16'h00FF << (8 * idx))) | (16'(a) << (8 * idx));
    req_b   = (req_b & ~(16'h00FF << (8 * idx))) | (16'(b) << (8 * idx));
    req_sel = (req_sel & ~(8'h0F << (4 * idx))) | (8'(sel) << (4 * idx));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    req_a = '0; req_b = '0; req_sel = '0;
    #12;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b want=00", rsp_valid); end
    checks++; if ({rsp_carry, rsp_data} !== 9'h000) begin errors++; $display("FAIL reset_rsp got=%h want=000", {rsp_carry, rsp_data}); end
    checks++; if ({alu_a, alu_b, alu_sel} !== 20'h0) begin errors++; $display("FAIL reset_alu got=%h want=00000", {alu_a, alu_b, alu_sel}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    last_grant = 1;
  endtask

  task automatic test_single_req0();
    set_req(0, 8'hF0, 8'h0F, 4'd0);
    req_valid = 2'b01; rsp_ready = 2'b00;
    settle();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL r0_accept got=%b want=01", req_ready); end
    tick(); req_valid = 2'b00; settle();
    checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL r0_exec got rr=%b rv=%b busy=%b want 00 00 1", req_ready, rsp_valid, busy); end
    checks++; if ({alu_a, alu_b, alu_sel} !== {8'hF0, 8'h0F, 4'd0}) begin errors++; $display("FAIL r0_alu_ops got=%h want=f00f0", {alu_a, alu_b, alu_sel}); end
    tick(); settle();
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL r0_rsp_valid got=%b want=01", rsp_valid); end
    checks++; if ({rsp_carry, rsp_data} !== 9'h0FF) begin errors++; $display("FAIL r0_rsp_data got=%h want=0ff", {rsp_carry, rsp_data}); end
    rsp_ready = 2'b01;
    tick(); settle();
    checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin errors++; $display("FAIL r0_release got busy=%b rv=%b want 0 00", busy, rsp_valid); end
    rsp_ready = 2'b00;
    last_grant = 0;
  endtask

  task automatic test_req1();
    set_req(1, 8'hFF, 8'h01, 4'd0);
    req_valid = 2'b10;
    settle();
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL r1_accept got=%b want=10", req_ready); end
    tick(); req_valid = 2'b00; tick(); settle();
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL r1_rsp_valid got=%b want=10", rsp_valid); end
    checks++; if ({rsp_carry, rsp_data} !== 9'h100) begin errors++; $display("FAIL r1_rsp_data got=%h want=100", {rsp_carry, rsp_data}); end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    last_grant = 1;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rr;
    logic [8:0] exp_res;
    int p;
    set_req(0, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 1)));
    set_req(1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 1)));
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int cyc = 0; cyc < 12; cyc++) begin
      settle();
      p = rr_pick(req_valid, last_grant);
      exp_rr = (cyc % 3 == 0) ? oh(p) : 2'b00;
      checks++; if (req_ready !== exp_rr) begin errors++; $display("FAIL b2b_grant cyc=%0d got=%b want=%b", cyc, req_ready, exp_rr); end
      if (cyc % 3 == 0) last_grant = p;
      if (cyc % 3 == 2) begin
        exp_res = alu_ref(slice8(req_a, last_grant), slice8(req_b, last_grant), 4'(req_sel >> (4 * last_grant)));
        checks++; if (rsp_valid !== oh(last_grant) || {rsp_carry, rsp_data} !== exp_res) begin
          errors++; $display("FAIL b2b_rsp cyc=%0d got rv=%b res=%h want rv=%b res=%h", cyc, rsp_valid, {rsp_carry, rsp_data}, oh(last_grant), exp_res);
        end
      end
      tick();
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
  endtask

  task automatic test_stall();
    logic [8:0] exp0;
    set_req(0, 8'h3C, 8'h5A, 4'd1);
    exp0 = alu_ref(8'h3C, 8'h5A, 4'd1);
    req_valid = 2'b01; rsp_ready = 2'b10;
    settle();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_accept got=%b want=01", req_ready); end
    last_grant = 0;
    tick();
    set_req(1, 8'h11, 8'h22, 4'd0);
    req_valid = 2'b10;
    settle();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_exec_ready got=%b want=00", req_ready); end
    tick();
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++; if (rsp_valid !== 2'b01 || {rsp_carry, rsp_data} !== exp0 || req_ready !== 2'b00 || busy !== 1'b1) begin
        errors++; $display("FAIL stall_hold i=%0d got rv=%b res=%h rr=%b busy=%b want 01 %h 00 1", i, rsp_valid, {rsp_carry, rsp_data}, req_ready, busy, exp0);
      end
      tick();
    end
    rsp_ready = 2'b01;
    settle();
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL stall_last_rsp got=%b want=01", rsp_valid); end
    tick(); settle();
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL stall_req1_grant got=%b want=10", req_ready); end
    last_grant = 1;
    tick(); req_valid = 2'b00; rsp_ready = 2'b11;
    tick(); settle();
    checks++; if (rsp_valid !== 2'b10 || {rsp_carry, rsp_data} !== 9'h033) begin errors++; $display("FAIL stall_req1_rsp got rv=%b res=%h want 10 033", rsp_valid, {rsp_carry, rsp_data}); end
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_exec();
    set_req(1, 8'hA5, 8'h5A, 4'd7);
    req_valid = 2'b10;
    settle();
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rst_accept got=%b want=10", req_ready); end
    tick(); req_valid = 2'b00; settle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got=%b want=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if ({req_ready, rsp_valid, busy, rsp_carry} !== 6'b0) begin errors++; $display("FAIL rst_exec_ctl got=%b want=000000", {req_ready, rsp_valid, busy, rsp_carry}); end
    checks++; if ({alu_a, alu_b, alu_sel, rsp_data} !== 28'h0) begin errors++; $display("FAIL rst_exec_data got=%h want=0000000", {alu_a, alu_b, alu_sel, rsp_data}); end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    last_grant = 1;
    tick();
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rst_after i=%0d got rv=%b busy=%b want 00 0", i, rsp_valid, busy); end
      tick();
    end
    req_valid = 2'b11;
    settle();
    checks++; if (req_ready !== oh(rr_pick(2'b11, last_grant))) begin errors++; $display("FAIL rst_next_grant got=%b want=01", req_ready); end
    last_grant = 0;
    tick(); req_valid = 2'b00;
    tick(); tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_random();
    bit         inflight = 1'b0;
    int         age = 0;
    int         w = 0;
    int         p;
    logic [7:0] ea = '0, eb = '0;
    logic [3:0] esel = '0;
    logic [8:0] exp_res = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      for (int r = 0; r < 2; r++) set_req(r, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
      settle();
      if (!inflight) begin
        p = rr_pick(req_valid, last_grant);
        checks++; if (req_ready !== ((p >= 0) ? oh(p) : 2'b00) || busy !== 1'b0 || rsp_valid !== 2'b00) begin
          errors++; $display("FAIL rnd_idle cyc=%0d got rr=%b busy=%b rv=%b want rr=%b busy=0 rv=00", cyc, req_ready, busy, rsp_valid, (p >= 0) ? oh(p) : 2'b00);
        end
        if (p >= 0) begin
          inflight = 1'b1; age = 0; w = p; last_grant = p;
          ea = slice8(req_a, p); eb = slice8(req_b, p); esel = 4'(req_sel >> (4 * p));
          exp_res = alu_ref(ea, eb, esel);
        end
      end else begin
        checks++; if (req_ready !== 2'b00 || busy !== 1'b1 || {alu_a, alu_b, alu_sel} !== {ea, eb, esel}) begin
          errors++; $display("FAIL rnd_busy cyc=%0d got rr=%b busy=%b alu=%h want 00 1 %h", cyc, req_ready, busy, {alu_a, alu_b, alu_sel}, {ea, eb, esel});
        end
        if (age == 0) begin
          checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rnd_exec_rv cyc=%0d got=%b want=00", cyc, rsp_valid); end
        end else begin
          checks++; if (rsp_valid !== oh(w) || {rsp_carry, rsp_data} !== exp_res) begin
            errors++; $display("FAIL rnd_rsp cyc=%0d got rv=%b res=%h want rv=%b res=%h", cyc, rsp_valid, {rsp_carry, rsp_data}, oh(w), exp_res);
          end
          if ((rsp_ready & oh(w)) != 2'b00) inflight = 1'b0;
        end
        age++;
      end
      tick();
    end
    req_valid = 2'b00; rsp_ready = 2'b11;
    tick(); tick(); tick();
    rsp_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_req1();
    test_back_to_back();
    test_stall();
    test_reset_exec();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
